// File: rtl/control_unit.sv
// Hardwired control sequencer for the mini CPU: fetches via PC/MAR/MDR into IR,
// decodes the opcode and walks a fixed T-state sequence per instruction class.
module control_unit (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic [15:0] Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rin,
    output logic [4:0]  op,
    output logic        Run
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_T0     = 4'd1;
    localparam logic [3:0] S_T1     = 4'd2;
    localparam logic [3:0] S_T2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_T6     = 4'd7;
    localparam logic [3:0] S_HALTED = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_r3, is_r2, is_md, is_imm, is_halt;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign ra_oh     = 16'(1) << IR[26:23];
    assign rb_oh     = 16'(1) << IR[22:19];
    assign rc_oh     = 16'(1) << IR[18:15];
    assign unused_ir = ^IR[14:0];

    // Instruction class decode
    always_comb begin
        is_r3   = 1'b0;
        is_r2   = 1'b0;
        is_md   = 1'b0;
        is_imm  = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01001, 5'b01010, 5'b01011, 5'b01100: is_r3   = 1'b1;
            5'b00111, 5'b01000:                     is_r2   = 1'b1;
            5'b01101, 5'b01110:                     is_md   = 1'b1;
            5'b01111, 5'b10000, 5'b10001:           is_imm  = 1'b1;
            5'b11011:                               is_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        Rout     = 16'h0000;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Zhighin  = 1'b0;
        Zlowin   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rin      = 16'h0000;
        op       = 5'd0;
        Run      = (state_q != S_HALTED);

        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_r3 || is_md || is_imm) begin
                    Rout = rb_oh; Yin = 1'b1;
                    state_d = S_T4;
                end else if (is_r2) begin
                    Rout = rb_oh; op = opcode; Zhighin = 1'b1; Zlowin = 1'b1;
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                if (is_r3) begin
                    Rout = rc_oh; op = opcode; Zlowin = 1'b1;
                    state_d = S_T5;
                end else if (is_md) begin
                    Rout = rc_oh; op = opcode; Zhighin = 1'b1; Zlowin = 1'b1;
                    state_d = S_T5;
                end else if (is_imm) begin
                    Cout = 1'b1; op = opcode; Zlowin = 1'b1;
                    state_d = S_T5;
                end else begin
                    if (is_r2) begin
                        Zlowout = 1'b1; Rin = ra_oh;
                    end
                    state_d = S_T0;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_md) begin
                    LOin = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin = ra_oh;
                    state_d = S_T0;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_d = S_T0;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of per-cycle expected controls plus
// hand sequences for halt hold, reset release and mid-instruction abort.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR    = 32'h0;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, IncPC, Read;
    logic        Run;
    logic [15:0] Rout, Rin;
    logic [4:0]  op;

    control_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .IncPC(IncPC), .Read(Read), .Rin(Rin), .op(op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    localparam logic [18:0] M_PCOUT    = 19'(1) << 18;
    localparam logic [18:0] M_MDROUT   = 19'(1) << 17;
    localparam logic [18:0] M_ZHIGHOUT = 19'(1) << 16;
    localparam logic [18:0] M_ZLOWOUT  = 19'(1) << 15;
    localparam logic [18:0] M_HIOUT    = 19'(1) << 14;
    localparam logic [18:0] M_LOOUT    = 19'(1) << 13;
    localparam logic [18:0] M_COUT     = 19'(1) << 12;
    localparam logic [18:0] M_MARIN    = 19'(1) << 11;
    localparam logic [18:0] M_PCIN     = 19'(1) << 10;
    localparam logic [18:0] M_MDRIN    = 19'(1) << 9;
    localparam logic [18:0] M_IRIN     = 19'(1) << 8;
    localparam logic [18:0] M_YIN      = 19'(1) << 7;
    localparam logic [18:0] M_HIIN     = 19'(1) << 6;
    localparam logic [18:0] M_LOIN     = 19'(1) << 5;
    localparam logic [18:0] M_ZHIGHIN  = 19'(1) << 4;
    localparam logic [18:0] M_ZLOWIN   = 19'(1) << 3;
    localparam logic [18:0] M_INCPC    = 19'(1) << 2;
    localparam logic [18:0] M_READ     = 19'(1) << 1;
    localparam logic [18:0] M_RUN      = 19'(1);

    localparam logic [18:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN;
    localparam logic [18:0] F_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [18:0] F_T2 = M_MDROUT | M_IRIN | M_RUN;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_NOT  = 32'h4310_0000;
    localparam logic [31:0] IR_MUL  = 32'h69A8_0000;
    localparam logic [31:0] IR_IMM  = 32'h7A20_0015;
    localparam logic [31:0] IR_ILL  = 32'hFFFF_FFFF;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [18:0] flags;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  op;
    } vec_t;

    logic [18:0] flags;
    assign flags = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout,
                    MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin,
                    IncPC, Read, Run};

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [18:0] ef, input logic [15:0] erout,
                         input logic [15:0] erin, input logic [4:0] eop);
        checks++;
        if (flags !== ef || Rout !== erout || Rin !== erin || op !== eop) begin
            errors++;
            $display("FAIL %s: flags=%05h Rout=%04h Rin=%04h op=%02h, required flags=%05h Rout=%04h Rin=%04h op=%02h",
                     name, flags, Rout, Rin, op, ef, erout, erin, eop);
        end
    endtask

    task automatic add(input string n, input logic [31:0] ir, input logic [18:0] f,
                       input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] o);
        vec_t v;
        v.name = n; v.ir = ir; v.flags = f; v.rout = ro; v.rin = ri; v.op = o;
        vecs.push_back(v);
    endtask

    // Fetch cycles use a junk IR to show T0-T2 ignore it
    task automatic add_fetch(input string n, input logic [31:0] junk);
        add({n, "_t0"}, junk, F_T0, 16'h0, 16'h0, 5'd0);
        add({n, "_t1"}, junk, F_T1, 16'h0, 16'h0, 5'd0);
        add({n, "_t2"}, junk, F_T2, 16'h0, 16'h0, 5'd0);
    endtask

    // Release clear just after an edge so RESET lasts a full cycle, then see T0
    task automatic release_and_check(input string n);
        @(posedge Clock); #1 clear = 1'b0;
        @(negedge Clock);
        check({n, "_reset"}, M_RUN, 16'h0, 16'h0, 5'd0);
        @(posedge Clock); @(negedge Clock);
        check({n, "_t0"}, F_T0, 16'h0, 16'h0, 5'd0);
    endtask

    task automatic step(input logic [31:0] ir);
        @(posedge Clock); #1 IR = ir;
        @(negedge Clock);
    endtask

    initial begin
        add_fetch("add", IR_ILL);
        add("add_t3", IR_ADD, M_YIN | M_RUN, 16'h0004, 16'h0, 5'd0);
        add("add_t4", IR_ADD, M_ZLOWIN | M_RUN, 16'h0008, 16'h0, 5'b00011);
        add("add_t5", IR_ADD, M_ZLOWOUT | M_RUN, 16'h0, 16'h0002, 5'd0);
        add_fetch("not", IR_ADD);
        add("not_t3", IR_NOT, M_ZHIGHIN | M_ZLOWIN | M_RUN, 16'h0004, 16'h0, 5'b01000);
        add("not_t4", IR_NOT, M_ZLOWOUT | M_RUN, 16'h0, 16'h0040, 5'd0);
        add_fetch("mul", IR_ILL);
        add("mul_t3", IR_MUL, M_YIN | M_RUN, 16'h0020, 16'h0, 5'd0);
        add("mul_t4", IR_MUL, M_ZHIGHIN | M_ZLOWIN | M_RUN, 16'h0001, 16'h0, 5'b01101);
        add("mul_t5", IR_MUL, M_ZLOWOUT | M_LOIN | M_RUN, 16'h0, 16'h0, 5'd0);
        add("mul_t6", IR_MUL, M_ZHIGHOUT | M_HIIN | M_RUN, 16'h0, 16'h0, 5'd0);
        add_fetch("imm", IR_MUL);
        add("imm_t3", IR_IMM, M_YIN | M_RUN, 16'h0010, 16'h0, 5'd0);
        add("imm_t4", IR_IMM, M_COUT | M_ZLOWIN | M_RUN, 16'h0, 16'h0, 5'b01111);
        add("imm_t5", IR_IMM, M_ZLOWOUT | M_RUN, 16'h0, 16'h0010, 5'd0);
        add_fetch("ill", IR_ADD);
        add("ill_t3", IR_ILL, M_RUN, 16'h0, 16'h0, 5'd0);
        add_fetch("nop", IR_ILL);
        add("nop_t3", IR_NOP, M_RUN, 16'h0, 16'h0, 5'd0);
        add_fetch("halt", IR_ADD);
        add("halt_t3", IR_HALT, M_RUN, 16'h0, 16'h0, 5'd0);

        // Asynchronous reset state
        #2 check("reset_async", M_RUN, 16'h0, 16'h0, 5'd0);
        release_and_check("boot");

        // Table starts at T1 since boot T0 was already checked
        for (int i = 1; i < vecs.size(); i++) begin
            step(vecs[i].ir);
            check(vecs[i].name, vecs[i].flags, vecs[i].rout, vecs[i].rin, vecs[i].op);
        end

        // HALTED holds with everything low, whatever IR says
        for (int i = 0; i < 25; i++) begin
            step((i % 2 == 0) ? IR_ADD : IR_MUL);
            check($sformatf("halted_%0d", i), 19'h0, 16'h0, 16'h0, 5'd0);
        end

        @(posedge Clock); #1 clear = 1'b1; IR = IR_ILL;
        #1 check("halt_clear", M_RUN, 16'h0, 16'h0, 5'd0);
        release_and_check("resume");

        // Abort an R3 add mid-T4
        step(IR_ILL);
        step(IR_ILL);
        step(IR_ADD);
        check("abort_t3", M_YIN | M_RUN, 16'h0004, 16'h0, 5'd0);
        step(IR_ADD);
        check("abort_t4", M_ZLOWIN | M_RUN, 16'h0008, 16'h0, 5'b00011);
        #1 clear = 1'b1;
        #1 check("abort_now", M_RUN, 16'h0, 16'h0, 5'd0);
        @(posedge Clock); @(negedge Clock);
        check("abort_hold", M_RUN, 16'h0, 16'h0, 5'd0);
        release_and_check("abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the mini CPU. It sits directly upstream of `data_path` and drives every bus-gate, register-load and ALU-op control that benches currently drive by hand. It fetches each instruction through PC/MAR/MDR into IR, decodes IR, and steps through a fixed T-state sequence per instruction class. Control outputs are a combinational function of the registered state and IR.

## Interface
- No parameters. Fixed: 16 GPRs, 5-bit opcode, 32-bit IR.
- `Clock`  in  1  — system clock; state advances on rising edge.
- `clear`  in  1  — asynchronous, active-high reset.
- `IR`  in  32  — instruction register contents from `data_path`.
  - `IR[31:27]` opcode; `IR[26:23]` Ra; `IR[22:19]` Rb; `IR[18:15]` Rc.
- `PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout`  out  1 each  — bus drivers.
  - `Cout` gates the datapath's sign-extended `IR[18:0]` onto the bus.
- `Rout`  out  16  — one-hot GPR bus driver; bit n maps to Rn.
- `MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, IncPC, Read`  out  1 each  — load enables.
- `Rin`  out  16  — one-hot GPR load enable.
- `op`  out  5  — ALU operation to `data_path`.
- `Run`  out  1  — 1 while executing, 0 when halted.

## Operation
- States: RESET, T0–T6, HALTED, held in a 4-bit state register.
- Outputs not listed for a state are 0. `op` = `IR[31:27]` only in the state marked "op", otherwise 0.
- Fetch:
  - T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
  - T3 decodes `IR`.
- Instruction classes:
  - **R3**, opcodes 00011, 00100, 00101, 00110, 01001, 01010, 01011, 01100: Ra ← Rb op Rc.
    - T3: Rout[Rb], `Yin`.
    - T4: Rout[Rc], op, `Zlowin`.
    - T5: `Zlowout`, Rin[Ra]. Then T0.
  - **R2**, opcodes 00111 (neg) and 01000 (not): Ra ← op Rb.
    - T3: Rout[Rb], op, `Zhighin`, `Zlowin`.
    - T4: `Zlowout`, Rin[Ra]. Then T0.
  - **MD**, opcodes 01101 (mul) and 01110 (div):
    - T3: Rout[Rb], `Yin`.
    - T4: Rout[Rc], op, `Zhighin`, `Zlowin`.
    - T5: `Zlowout`, `LOin`.
    - T6: `Zhighout`, `HIin`. Then T0.
  - **IMM**, opcodes 01111, 10000, 10001: Ra ← Rb op sext(C).
    - T3: Rout[Rb], `Yin`.
    - T4: `Cout`, op, `Zlowin`.
    - T5: `Zlowout`, Rin[Ra]. Then T0.
  - **HALT**, opcode 11011: T3 → HALTED.
  - **All other opcodes**, including 11010 nop: T3 asserts nothing, then T0.
- HALTED: all controls 0 and `Run`=0. The block stays in HALTED until `clear`.
- RESET: all controls 0. Advances to T0 on the next edge.
- Ra = Rb or Rb = Rc needs no special handling.
- At most one bus driver is asserted in any state. `Rout` and `Rin` are always one-hot or zero.

## Timing
- Reset values, asynchronous on `clear`:
  - state = RESET.
  - Every control output and `op` = 0.
  - `Run` = 1.
- `clear` asserted mid-instruction aborts the instruction immediately. Outputs drop to 0 in the same cycle, with no further register loads.
- Cycles per instruction, counted from T0 to the next T0, including 3 fetch cycles:
  - R3 = 6.
  - R2 = 5.
  - MD = 7.
  - IMM = 6.
  - nop/illegal = 4.
- After `clear` deasserts, the first T0 occurs one edge later, because RESET lasts one cycle.
- Outputs change only after a rising edge and are stable for the full cycle. `data_path` registers sample on the next rising edge.
- `IR` is sampled only from T3 onward. Its value in T0–T2 has no effect on outputs.

## Test plan
- Reset then run: assert `clear` in T4 of an R3 instruction.
  - Required: all outputs 0 at once.
  - After release: RESET for 1 cycle, then T0 with `PCout`=`MARin`=`IncPC`=`Zlowin`=1.
- R3 add with IR=0x18918000 (00011, Ra=1, Rb=2, Rc=3). Required:
  - T3: `Rout`=0x0004, `Yin`=1.
  - T4: `Rout`=0x0008, `op`=00011, `Zlowin`=1.
  - T5: `Rin`=0x0002.
  - Next T0 exactly 6 cycles after the first T0.
- R2 not with IR=0x43100000 (01000, Ra=6, Rb=2). Required:
  - T3: `Rout`=0x0004, `op`=01000, `Zhighin`=`Zlowin`=1.
  - T4: `Zlowout`=1, `Rin`=0x0040.
  - 5-cycle instruction.
- MD mul with IR=0x69A8_0000 (Rb=5, Rc=0). Required:
  - T5: `LOin` with `Zlowout`.
  - T6: `HIin` with `Zhighout`.
  - 7-cycle instruction.
  - `Rin` is never asserted.
- IMM with opcode 01111, Ra=4, Rb=4. Required:
  - T4: `Cout`=1, `Rout`=0.
  - T5: `Rin`=0x0010.
- HALT with opcode 11011. Required:
  - After T3: `Run`=0 and all controls 0 for 20+ cycles.
  - `clear` restores `Run`=1 and fetch resumes.
- Opcode 11111: no outputs asserted in T3, and next T0 after 4 cycles.
